// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add multiplier and its sequencer for MUL/MLA in the execute
// stage. Retires BITS_PER_CYCLE multiplier bits per RUN cycle. An optional ACC cycle adds the
// MLA accumulator. The low WIDTH bits of the result and the N/Z flags are then published.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      multiply request (MulOpE & CondExE), honoured only in IDLE
//   mla        1: multiply-accumulate, 0: plain multiply
//   set_flags  update n_flag/z_flag when the operation completes
//   flush      abort the operation in flight (wins over start)
//   src_a      multiplicand (Rm)
//   src_b      multiplier (Rs)
//   src_acc    accumulator (Ra), sampled only for MLA
//   stall_e    hold F/D/E while the multiply occupies the stage
//   done       one-cycle pulse, result valid
//   result     low WIDTH bits of product (+acc), held until the next completion
//   n_flag     result MSB, latched at completion if set_flags
//   z_flag     result == 0, latched at completion if set_flags
//   busy       sequencer not idle
module mul_sequencer #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 2,
   parameter int unsigned EARLY_TERM     = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mla,
   input  logic             set_flags,
   input  logic             flush,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [WIDTH-1:0] src_acc,
   output logic             stall_e,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             n_flag,
   output logic             z_flag,
   output logic             busy
);

   localparam int unsigned Steps = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned StepW = (Steps > 1) ? $clog2(Steps) : 1;
   localparam logic [StepW-1:0] LastStep = StepW'(Steps - 1);

   typedef enum logic [1:0] {StIdle, StRun, StAcc, StDone} stateT;

   stateT               stateQ;
   logic [WIDTH-1:0]    mcandQ, mplierQ, accQ, partialQ, resultQ;
   logic [StepW-1:0]    stepQ;
   logic                mlaQ, setFlagsQ, doneQ, nFlagQ, zFlagQ;

   logic [WIDTH-1:0]    stepSum, accSum, mplierShifted, finalSum;
   logic                lastStep, enterDone;

   always_comb begin
      stepSum       = partialQ + mcandQ * WIDTH'(mplierQ[BITS_PER_CYCLE-1:0]);
      accSum        = partialQ + accQ;
      mplierShifted = mplierQ >> BITS_PER_CYCLE;
      // Early exit once no set multiplier bits remain beyond the digit just retired.
      lastStep      = (stepQ == LastStep) || ((EARLY_TERM != 0) && (mplierShifted == '0));
      // Result and flags are committed on the edge into DONE so they are valid with done.
      enterDone     = !flush && (((stateQ == StRun) && lastStep && !mlaQ) || (stateQ == StAcc));
      finalSum      = (stateQ == StAcc) ? accSum : stepSum;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ    <= StIdle;
         mcandQ    <= '0;
         mplierQ   <= '0;
         accQ      <= '0;
         partialQ  <= '0;
         resultQ   <= '0;
         stepQ     <= '0;
         mlaQ      <= 1'b0;
         setFlagsQ <= 1'b0;
         doneQ     <= 1'b0;
         nFlagQ    <= 1'b0;
         zFlagQ    <= 1'b0;
      end else begin
         doneQ <= 1'b0;
         if (flush) begin
            stateQ <= StIdle;
         end else begin
            unique case (stateQ)
               StIdle: begin
                  if (start) begin
                     mcandQ    <= src_a;
                     mplierQ   <= src_b;
                     mlaQ      <= mla;
                     setFlagsQ <= set_flags;
                     if (mla) begin
                        accQ <= src_acc;
                     end
                     partialQ  <= '0;
                     stepQ     <= '0;
                     stateQ    <= StRun;
                  end
               end
               StRun: begin
                  partialQ <= stepSum;
                  mcandQ   <= mcandQ << BITS_PER_CYCLE;
                  mplierQ  <= mplierShifted;
                  stepQ    <= stepQ + StepW'(1);
                  if (lastStep) begin
                     stateQ <= mlaQ ? StAcc : StDone;
                  end
               end
               StAcc: begin
                  partialQ <= accSum;
                  stateQ   <= StDone;
               end
               StDone: begin
                  stateQ <= StIdle;
               end
               default: begin
                  stateQ <= StIdle;
               end
            endcase
         end
         if (enterDone) begin
            doneQ   <= 1'b1;
            resultQ <= finalSum;
            if (setFlagsQ) begin
               nFlagQ <= finalSum[WIDTH-1];
               zFlagQ <= (finalSum == '0);
            end
         end
      end
   end

   assign stall_e = ((stateQ == StIdle) && start && !flush) || (stateQ == StRun) ||
                    (stateQ == StAcc);
   assign busy    = (stateQ != StIdle);
   assign done    = doneQ;
   assign result  = resultQ;
   assign n_flag  = nFlagQ;
   assign z_flag  = zFlagQ;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: two instances (EARLY_TERM=0 and 1) share one stimulus stream and are
// compared cycle by cycle against an arithmetic reference of result, flags and timing.
module tb_mul_sequencer;
   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0, mla = 1'b0, setFlags = 1'b0, flush = 1'b0;
   logic [W-1:0]  srcA = '0, srcB = '0, srcAcc = '0;
   logic [1:0]    stallV, doneV, busyV, nV, zV;
   logic [W-1:0]  res0, res1;

   int            nVec = 0;
   int            nBad = 0;

   logic [W-1:0]  expRes0 = '0, expRes1 = '0;
   logic [1:0]    expN = '0, expZ = '0;

   always #5 clk = ~clk;

   mul_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(2), .EARLY_TERM(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .mla(mla), .set_flags(setFlags), .flush(flush),
      .src_a(srcA), .src_b(srcB), .src_acc(srcAcc), .stall_e(stallV[0]), .done(doneV[0]),
      .result(res0), .n_flag(nV[0]), .z_flag(zV[0]), .busy(busyV[0])
   );

   mul_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(2), .EARLY_TERM(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .mla(mla), .set_flags(setFlags), .flush(flush),
      .src_a(srcA), .src_b(srcB), .src_acc(srcAcc), .stall_e(stallV[1]), .done(doneV[1]),
      .result(res1), .n_flag(nV[1]), .z_flag(zV[1]), .busy(busyV[1])
   );

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] want);
      nVec++;
      if (got !== want) begin
         nBad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, want);
      end
   endtask

   function automatic logic [W-1:0] refResult(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] acc, input logic m);
      logic [63:0] p;
      p = 64'(a) * 64'(b) + (m ? 64'(acc) : 64'd0);
      return p[W-1:0];
   endfunction

   // Cycle (counted from the request cycle = 0) in which done is expected.
   function automatic int refLatency(input logic [W-1:0] b, input logic m, input bit et);
      int steps;
      steps = W / 2;
      if (et) begin
         steps = 1;
         for (int i = 0; i < W / 2; i++) begin
            if (((b >> (2 * i)) & 32'd3) != 0) steps = i + 1;
         end
      end
      return steps + 1 + (m ? 1 : 0);
   endfunction

   task automatic checkOutputs();
      checkEq("result0", res0, expRes0);
      checkEq("result1", res1, expRes1);
      checkEq("n_flag", nV, expN);
      checkEq("z_flag", zV, expZ);
   endtask

   // One request at the current negedge; flushAt < 1 means no flush.
   task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] acc,
                        input logic m, input logic sf, input bit noise, input int flushAt);
      int          lat[2];
      int          endC[2];
      bit          fin[2];
      int          lim, last;
      logic [W-1:0] want;
      logic [1:0]  eStall, eDone, eBusy;
      want   = refResult(a, b, acc, m);
      lat[0] = refLatency(b, m, 1'b0);
      lat[1] = refLatency(b, m, 1'b1);
      for (int d = 0; d < 2; d++) begin
         fin[d]  = !(flushAt >= 1 && flushAt < lat[d]);
         endC[d] = fin[d] ? lat[d] : flushAt;
      end
      lim  = (endC[0] < endC[1]) ? endC[0] : endC[1];
      last = (endC[0] > endC[1]) ? endC[0] : endC[1];

      srcA = a; srcB = b; srcAcc = acc; mla = m; setFlags = sf; start = 1'b1; flush = 1'b0;
      #1;
      checkEq("stall_req", stallV, 2'b11);
      @(negedge clk);
      // Scramble operands to show they were latched at the start edge.
      srcA = $urandom; srcB = $urandom; srcAcc = $urandom;
      mla = 1'($urandom); setFlags = 1'($urandom);
      for (int c = 1; c <= last + 1; c++) begin
         start = (noise && c <= lim) ? 1'($urandom) : 1'b0;
         flush = (c == flushAt);
         #1;
         for (int d = 0; d < 2; d++) begin
            eStall[d] = fin[d] ? (c < lat[d]) : (c <= flushAt);
            eBusy[d]  = (c <= endC[d]);
            eDone[d]  = fin[d] && (c == lat[d]);
            if (eDone[d]) begin
               if (d == 0) expRes0 = want;
               else        expRes1 = want;
               if (sf) begin
                  expN[d] = want[W-1];
                  expZ[d] = (want == '0);
               end
            end
         end
         checkEq("stall_e", stallV, eStall);
         checkEq("busy", busyV, eBusy);
         checkEq("done", doneV, eDone);
         checkOutputs();
         @(negedge clk);
      end
      start = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] a, b, acc;
      int           fa;
      repeat (2) @(negedge clk);
      checkEq("reset_ctrl", {stallV, doneV, busyV, nV, zV}, 10'd0);
      checkOutputs();
      reset = 1'b1;
      @(negedge clk);

      // Basic MUL, MLA overflow with flags, zero multiplier with early exit.
      runOp(32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 0);
      runOp(32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b1, 1'b0, 0);
      runOp(32'd7, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 0);

      // Flush mid-RUN, then a normal op right after.
      runOp(32'h1234_5678, 32'hC000_0001, 32'd0, 1'b0, 1'b1, 1'b0, 6);
      runOp(32'd11, 32'd13, 32'd0, 1'b0, 1'b1, 1'b0, 0);

      // Spurious starts during RUN and alongside a flush; flush in DONE still commits.
      runOp(32'hDEAD_BEEF, 32'h8000_0003, 32'd5, 1'b1, 1'b1, 1'b1, 9);
      runOp(32'hDEAD_BEEF, 32'h8000_0003, 32'd0, 1'b0, 1'b1, 1'b1, 17);

      // start together with flush in IDLE is dropped.
      start = 1'b1; flush = 1'b1; srcA = 32'd9; srcB = 32'd9;
      #1;
      checkEq("stall_flush_start", stallV, 2'b00);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      checkEq("busy_flush_start", busyV, 2'b00);
      @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         a   = $urandom;
         acc = $urandom;
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = $urandom & 32'hFF;
            2:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 19)) : 0;
         runOp(a, b, acc, 1'($urandom), 1'($urandom), 1'($urandom), fa);
      end

      // Asynchronous reset in the middle of RUN.
      srcA = 32'h55; srcB = 32'hFFFF_FFFF; mla = 1'b0; setFlags = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checkEq("reset_async", {stallV, busyV, doneV}, 6'd0);
      expRes0 = '0; expRes1 = '0; expN = '0; expZ = '0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkEq("reset_release", {stallV, doneV, busyV, nV, zV}, 10'd0);
      checkOutputs();
      @(negedge clk);
      runOp(32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
